// File: rtl/life_step_engine.sv
// One Game-of-Life (B3/S23) generation over a row-packed grid. A 3-row window slides down the grid.
// Each output row is written every 2 cycles. No wrap-around at the grid edges.
module life_step_engine #(
  parameter int COLS = 40,
  parameter int ROWS = 30,
  parameter int AW   = 5,
  parameter int CW   = 11
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   rd_addr,
  input  logic [COLS-1:0] rd_data,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [COLS-1:0] wr_data,
  output logic [CW-1:0]   live_count,
  output logic            changed
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_PRE_W, S_RD, S_WR, S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   row;
  logic [COLS-1:0] prv, cur, nxt, nrow;
  logic            last_row;

  function automatic logic [CW-1:0] popcnt(input logic [COLS-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < COLS; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  assign last_row = (row == AW'(ROWS - 1));
  // Row below the last one is outside the grid and therefore dead.
  assign nxt = last_row ? '0 : rd_data;

  // Shifting left brings bit i-1 into position i; zeros fill the edges.
  always_comb begin
    logic [COLS-1:0] pl, pr, cl, cr, nl, nr;
    logic [3:0]      n;
    pl = prv << 1;
    pr = prv >> 1;
    cl = cur << 1;
    cr = cur >> 1;
    nl = nxt << 1;
    nr = nxt >> 1;
    nrow = '0;
    for (int i = 0; i < COLS; i++) begin
      n = 4'(pl[i]) + 4'(prv[i]) + 4'(pr[i]) + 4'(cl[i]) + 4'(cr[i]) +
          4'(nl[i]) + 4'(nxt[i]) + 4'(nr[i]);
      nrow[i] = (n == 4'd3) || (cur[i] && (n == 4'd2));
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_PRE;
      S_PRE:   state_nx = S_PRE_W;
      S_PRE_W: state_nx = S_RD;
      S_RD:    state_nx = S_WR;
      S_WR:    state_nx = last_row ? S_DONE : S_RD;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
    wr_en   = (state == S_WR);
    rd_addr = (state == S_RD) ? row + AW'(1) : '0;
    wr_addr = wr_en ? row : '0;
    wr_data = wr_en ? nrow : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      row        <= '0;
      prv        <= '0;
      cur        <= '0;
      live_count <= '0;
      changed    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_PRE: begin
          row        <= '0;
          live_count <= '0;
          changed    <= 1'b0;
        end
        S_PRE_W: begin
          cur <= rd_data;
          prv <= '0;
        end
        S_WR: begin
          prv        <= cur;
          cur        <= nxt;
          row        <= row + AW'(1);
          live_count <= live_count + popcnt(nrow);
          changed    <= changed | (|(nrow ^ cur));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_life_step_engine.sv
// Directed bench for life_step_engine: RAM model, write/done monitor, hand-computed expected grids.
module tb_life_step_engine;
  localparam int COLS = 40;
  localparam int ROWS = 30;
  localparam int AW   = 5;
  localparam int CW   = 11;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            busy, done, wr_en, changed;
  logic [AW-1:0]   rd_addr, wr_addr;
  logic [COLS-1:0] rd_data, wr_data;
  logic [CW-1:0]   live_count;

  logic [COLS-1:0] grid     [ROWS];
  logic [COLS-1:0] exp_grid [ROWS];
  logic [COLS-1:0] out_grid [ROWS];

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  int t0       = 0;
  int wr_cnt, done_cnt, done_rel, order_ok;

  life_step_engine #(.COLS(COLS), .ROWS(ROWS), .AW(AW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .live_count(live_count), .changed(changed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    rd_data  <= (int'(rd_addr) < ROWS) ? grid[int'(rd_addr)] : '0;
  end

  // Writes are expected at relative cycles 4,6,... with ascending addresses.
  always @(negedge clk) begin
    if (wr_en) begin
      if (int'(wr_addr) < ROWS) out_grid[int'(wr_addr)] = wr_data;
      if (int'(wr_addr) != wr_cnt || (edge_cnt - t0) != 4 + 2 * wr_cnt) order_ok = 0;
      wr_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_rel = edge_cnt - t0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_grids();
    for (int r = 0; r < ROWS; r++) begin
      grid[r]     = '0;
      exp_grid[r] = '0;
      out_grid[r] = '0;
    end
  endtask

  task automatic set_in(input int r, input int c);
    grid[r][COLS-1-c] = 1'b1;
  endtask

  task automatic set_exp(input int r, input int c);
    exp_grid[r][COLS-1-c] = 1'b1;
  endtask

  task automatic reset_log();
    wr_cnt   = 0;
    done_cnt = 0;
    done_rel = -1;
    order_ok = 1;
  endtask

  task automatic run_gen(input string name, input int exp_live, input int exp_chg);
    int bad;
    reset_log();
    @(negedge clk);
    start = 1'b1;
    t0    = edge_cnt;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy"}, 64'(busy), 64'd1);
    for (int i = 0; i < 200 && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({name, "_done_cycle"}, 64'(done_rel), 64'(2 * ROWS + 3));
    check({name, "_wr_cnt"}, 64'(wr_cnt), 64'(ROWS));
    check({name, "_wr_order"}, 64'(order_ok), 64'd1);
    check({name, "_live"}, 64'(live_count), 64'(exp_live));
    check({name, "_changed"}, 64'(changed), 64'(exp_chg));
    check({name, "_idle"}, 64'(busy), 64'd0);
    bad = 0;
    for (int r = 0; r < ROWS; r++) if (out_grid[r] !== exp_grid[r]) bad++;
    check({name, "_grid_bad_rows"}, 64'(bad), 64'd0);
  endtask

  task automatic setup_blinker();
    clear_grids();
    set_in(14, 19); set_in(14, 20); set_in(14, 21);
    set_exp(13, 20); set_exp(14, 20); set_exp(15, 20);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    clear_grids();
    reset_log();
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_live", 64'(live_count), 64'd0);
    check("rst_changed", 64'(changed), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    setup_blinker();
    run_gen("t1", 3, 1);

    clear_grids();
    for (int r = 5; r <= 6; r++)
      for (int c = 10; c <= 11; c++) begin
        set_in(r, c);
        set_exp(r, c);
      end
    run_gen("t2", 4, 0);

    clear_grids();
    run_gen("t3", 0, 0);

    clear_grids();
    set_in(0, 0); set_in(0, 1); set_in(0, 2);
    set_exp(0, 1); set_exp(1, 1);
    run_gen("t4", 2, 1);

    clear_grids();
    for (int r = 0; r < ROWS; r++) grid[r] = '1;
    set_exp(0, 0); set_exp(0, COLS - 1);
    set_exp(ROWS - 1, 0); set_exp(ROWS - 1, COLS - 1);
    run_gen("t5", 4, 1);

    // Restart attempt mid-run, then reset mid-run.
    setup_blinker();
    reset_log();
    @(negedge clk);
    start = 1'b1;
    t0    = edge_cnt;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_wr_en", 64'(wr_en), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_live", 64'(live_count), 64'd0);
    reset = 1'b0;
    repeat (80) @(negedge clk);
    check("t6_no_done", 64'(done_cnt), 64'd0);
    check("t6_partial_wr", 64'(wr_cnt), 64'd9);
    check("t6_partial_order", 64'(order_ok), 64'd1);
    check("t6_rd_addr_idle", 64'(rd_addr), 64'd0);
    setup_blinker();
    run_gen("t6", 3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
